// File: rtl/frontend_pkg.sv
// ----------------------------------------------------------------------------
// frontend_pkg
// Shared definitions for the MIPS fetch/decode flow-control logic:
//   - opcode / funct encodings of the flow-changing instructions
//   - default branch-history counter width and its typedef
//   - decode helpers (jr detection, taken-target computation)
// ----------------------------------------------------------------------------
package frontend_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    // R-type funct field (instr[5:0])
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Link register used by jal; jr through it is treated as a return
    localparam logic [4:0] RA_REG   = 5'd31;

    // Default branch-history counter width
    localparam int BHT_CNT_W = 2;
    typedef logic [BHT_CNT_W-1:0] bht_cnt_t;

    // True for any jr (R-type with funct JR), regardless of rs
    function automatic logic is_jr(input logic [31:0] instr);
        is_jr = (instr[31:26] == OP_RTYPE) && (instr[5:0] == FN_JR);
    endfunction

    // True for jr $31, i.e. a subroutine return
    function automatic logic is_ret(input logic [31:0] instr);
        is_ret = is_jr(instr) && (instr[25:21] == RA_REG);
    endfunction

    // Taken target of a flow instruction located at pc:
    //   j/jal    -> pseudo-direct {P4[31:28], instr_index, 00}
    //   anything else is treated as a PC-relative branch P4 + sext(imm16)*4
    // All arithmetic wraps mod 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                  input logic [31:0] instr);
        logic [31:0] p4;
        logic [31:0] offset;
        p4     = pc + 32'd4;
        offset = {{14{instr[15]}}, instr[15:0], 2'b00};
        if ((instr[31:26] == OP_J) || (instr[31:26] == OP_JAL)) begin
            branch_target = {p4[31:28], instr[25:0], 2'b00};
        end else begin
            branch_target = p4 + offset;
        end
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// ----------------------------------------------------------------------------
// return_addr_stack
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry and the occupancy saturates at DEPTH; a pop on an empty stack
// is ignored. If push and pop arrive together the push wins (cannot occur
// for a single fetched instruction, but keeps behaviour defined).
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous, active-high; clears pointer, count, entries
//   push       in   1   write push_data on top
//   pop        in   1   discard top entry (no-op when empty)
//   push_data  in  32   return address to push
//   top        out 32   current top-of-stack value
//   empty      out  1   no valid entries
// ----------------------------------------------------------------------------
module return_addr_stack
    import frontend_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // sp points at the next slot to write; top lives at sp-1
    logic [31:0]      entries_q [DEPTH];
    logic [31:0]      entries_d [DEPTH];
    logic [PTR_W-1:0] sp_q;
    logic [PTR_W-1:0] sp_d;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;

    // Next-state computation for push / pop
    always_comb begin
        entries_d = entries_q;
        sp_d      = sp_q;
        count_d   = count_q;
        if (push) begin
            entries_d[sp_q] = push_data;
            sp_d            = sp_q + PTR_ONE;
            if (count_q != CNT_FULL) begin
                count_d = count_q + CNT_ONE;
            end else begin
                count_d = count_q;
            end
        end else if (pop && (count_q != CNT_ZERO)) begin
            sp_d    = sp_q - PTR_ONE;
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= 32'd0;
            end
            sp_q    <= '0;
            count_q <= CNT_ZERO;
        end else begin
            entries_q <= entries_d;
            sp_q      <= sp_d;
            count_q   <= count_d;
        end
    end

    assign top   = entries_q[sp_q - PTR_ONE];
    assign empty = (count_q == CNT_ZERO);

endmodule

// File: rtl/branch_predict_unit.sv
// ----------------------------------------------------------------------------
// branch_predict_unit
// Fetch-stage next-PC predictor and decode-stage resolver for a MIPS pipeline
// without delay slots.
//   Fetch  : beq/bne use a BHT of saturating counters, j/jal are always taken
//            to their direct target, jr $31 is predicted from a speculative
//            return-address stack. Prediction is purely combinational.
//   Decode : the instruction in decode is resolved against its real outcome;
//            a difference from the PC predicted at fetch raises redirect.
// Ports:
//   clk, reset               clock and synchronous active-high reset
//   stall                    freeze BHT and RAS this cycle
//   fetch_pc, fetch_instr    instruction being fetched
//   pred_taken, pred_pc      prediction for it
//   res_valid, res_pc, res_instr, res_pred_pc, res_eq, res_vs
//                            instruction in decode, its prediction, and operands
//   redirect, redirect_pc    misprediction flag and correct next PC
// ----------------------------------------------------------------------------
module branch_predict_unit
    import frontend_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = BHT_CNT_W,
    parameter int CNT_INIT    = 2,
    parameter int RAS_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_instr,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic [31:0] res_instr,
    input  logic [31:0] res_pred_pc,
    input  logic        res_eq,
    input  logic [31:0] res_vs,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_RST  = CNT_W'(CNT_INIT);

    // ------------------------------------------------------------------
    // Branch history table
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] bht_q [BHT_ENTRIES];
    logic [CNT_W-1:0] bht_d [BHT_ENTRIES];

    // ------------------------------------------------------------------
    // Fetch-side decode
    // ------------------------------------------------------------------
    logic [5:0]       fetch_op_s;
    logic [31:0]      fetch_p4_s;
    logic [31:0]      fetch_target_s;
    logic [IDX_W-1:0] fetch_idx_s;
    logic             fetch_is_ret_s;

    assign fetch_op_s     = fetch_instr[31:26];
    assign fetch_p4_s     = fetch_pc + 32'd4;
    assign fetch_target_s = branch_target(fetch_pc, fetch_instr);
    assign fetch_idx_s    = fetch_pc[IDX_W+1:2];
    assign fetch_is_ret_s = is_ret(fetch_instr);

    // RAS interface
    logic        ras_push_s;
    logic        ras_pop_s;
    logic [31:0] ras_top_s;
    logic        ras_empty_s;

    // Next-PC prediction for the fetched instruction
    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = fetch_p4_s;
        case (fetch_op_s)
            OP_BEQ, OP_BNE: begin
                // BHT read sees the pre-update value on a same-cycle write
                pred_taken = bht_q[fetch_idx_s][CNT_W-1];
                if (bht_q[fetch_idx_s][CNT_W-1]) begin
                    pred_pc = fetch_target_s;
                end else begin
                    pred_pc = fetch_p4_s;
                end
            end
            OP_J, OP_JAL: begin
                pred_taken = 1'b1;
                pred_pc    = fetch_target_s;
            end
            OP_RTYPE: begin
                if (fetch_is_ret_s && !ras_empty_s) begin
                    pred_taken = 1'b1;
                    pred_pc    = ras_top_s;
                end else begin
                    pred_taken = 1'b0;
                    pred_pc    = fetch_p4_s;
                end
            end
            default: begin
                pred_taken = 1'b0;
                pred_pc    = fetch_p4_s;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Decode-side resolution
    // ------------------------------------------------------------------
    logic [5:0]       res_op_s;
    logic [31:0]      res_p4_s;
    logic [31:0]      res_target_s;
    logic [IDX_W-1:0] res_idx_s;
    logic [31:0]      actual_pc_s;
    logic             res_is_br_s;
    logic             res_br_taken_s;

    assign res_op_s     = res_instr[31:26];
    assign res_p4_s     = res_pc + 32'd4;
    assign res_target_s = branch_target(res_pc, res_instr);
    assign res_idx_s    = res_pc[IDX_W+1:2];

    // Architecturally correct next PC of the decode instruction
    always_comb begin
        actual_pc_s    = res_p4_s;
        res_is_br_s    = 1'b0;
        res_br_taken_s = 1'b0;
        case (res_op_s)
            OP_BEQ: begin
                res_is_br_s    = 1'b1;
                res_br_taken_s = res_eq;
                actual_pc_s    = res_eq ? res_target_s : res_p4_s;
            end
            OP_BNE: begin
                res_is_br_s    = 1'b1;
                res_br_taken_s = !res_eq;
                actual_pc_s    = res_eq ? res_p4_s : res_target_s;
            end
            OP_J, OP_JAL: begin
                actual_pc_s = res_target_s;
            end
            OP_RTYPE: begin
                if (is_jr(res_instr)) begin
                    actual_pc_s = res_vs;
                end else begin
                    actual_pc_s = res_p4_s;
                end
            end
            default: begin
                actual_pc_s = res_p4_s;
            end
        endcase
    end

    // Misprediction detection; quiet while idle or in reset
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        if (res_valid && !reset) begin
            redirect    = (actual_pc_s != res_pred_pc);
            redirect_pc = actual_pc_s;
        end else begin
            redirect    = 1'b0;
            redirect_pc = 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // BHT training
    // ------------------------------------------------------------------
    logic             bht_we_s;
    logic [CNT_W-1:0] cur_cnt_s;

    assign bht_we_s  = res_valid && res_is_br_s && !stall;
    assign cur_cnt_s = bht_q[res_idx_s];

    // Saturating counter update toward the resolved direction
    always_comb begin
        bht_d = bht_q;
        if (bht_we_s) begin
            if (res_br_taken_s) begin
                if (cur_cnt_s != CNT_MAX) begin
                    bht_d[res_idx_s] = cur_cnt_s + CNT_ONE;
                end else begin
                    bht_d[res_idx_s] = cur_cnt_s;
                end
            end else begin
                if (cur_cnt_s != CNT_ZERO) begin
                    bht_d[res_idx_s] = cur_cnt_s - CNT_ONE;
                end else begin
                    bht_d[res_idx_s] = cur_cnt_s;
                end
            end
        end else begin
            bht_d[res_idx_s] = cur_cnt_s;
        end
    end

    // BHT registers; reset returns every counter to its initial bias
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= CNT_RST;
            end
        end else begin
            bht_q <= bht_d;
        end
    end

    // ------------------------------------------------------------------
    // Speculative return-address stack, driven from fetch.
    // A redirect means the fetched instruction is wrong-path, so its
    // push/pop is dropped; no other repair is attempted.
    // ------------------------------------------------------------------
    assign ras_push_s = !stall && !redirect && (fetch_op_s == OP_JAL);
    assign ras_pop_s  = !stall && !redirect && fetch_is_ret_s;

    return_addr_stack #(
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push_s),
        .pop       (ras_pop_s),
        .push_data (fetch_p4_s),
        .top       (ras_top_s),
        .empty     (ras_empty_s)
    );

endmodule

// File: tb/tb_branch_predict_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_predict_unit
// Self-checking bench: a behavioural model (counter array + queue as RAS)
// predicts every output each cycle; directed sequences pin the model with
// literal expectations, then randomized traffic exercises the rest.
// ----------------------------------------------------------------------------
module tb_branch_predict_unit;

    localparam int NB   = 16;
    localparam int NRAS = 4;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, stall, res_valid, res_eq;
    logic [31:0] fetch_pc, fetch_instr, res_pc, res_instr, res_pred_pc, res_vs;
    logic        pred_taken, redirect;
    logic [31:0] pred_pc, redirect_pc;

    int n_cmp  = 0;
    int n_fail = 0;

    // model state
    int          m_bht [NB];
    logic [31:0] m_ras [$];

    // outputs sampled in the most recent cycle
    logic        s_pred_taken, s_redirect;
    logic [31:0] s_pred_pc, s_redirect_pc;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .fetch_pc    (fetch_pc),
        .fetch_instr (fetch_instr),
        .pred_taken  (pred_taken),
        .pred_pc     (pred_pc),
        .res_valid   (res_valid),
        .res_pc      (res_pc),
        .res_instr   (res_instr),
        .res_pred_pc (res_pred_pc),
        .res_eq      (res_eq),
        .res_vs      (res_vs),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_br(input logic bne, input logic [15:0] imm);
        return {(bne ? 6'd5 : 6'd4), 5'd1, 5'd2, imm};
    endfunction
    function automatic logic [31:0] enc_j(input logic link, input logic [25:0] idx);
        return {(link ? 6'd3 : 6'd2), idx};
    endfunction
    function automatic logic [31:0] enc_jr(input logic [4:0] rs);
        return {6'd0, rs, 15'd0, 6'd8};
    endfunction

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] m_target(input logic [31:0] pc, input logic [31:0] ins);
        logic [31:0] p4;
        int          off;
        p4 = pc + 32'd4;
        if (ins[31:26] == 6'd2 || ins[31:26] == 6'd3) return {p4[31:28], ins[25:0], 2'b00};
        off = int'($signed(ins[15:0])) * 4;
        return p4 + 32'(off);
    endfunction

    function automatic bit m_is_jr(input logic [31:0] ins);
        return ins[31:26] == 6'd0 && ins[5:0] == 6'd8;
    endfunction

    function automatic bit m_is_ret(input logic [31:0] ins);
        return m_is_jr(ins) && ins[25:21] == 5'd31;
    endfunction

    task automatic m_predict(output logic t, output logic [31:0] pc);
        logic [5:0] op;
        op = fetch_instr[31:26];
        t  = 1'b0;
        pc = fetch_pc + 32'd4;
        if (op == 6'd4 || op == 6'd5) begin
            t = (m_bht[int'(fetch_pc[5:2])] >= 2);
            if (t) pc = m_target(fetch_pc, fetch_instr);
        end else if (op == 6'd2 || op == 6'd3) begin
            t  = 1'b1;
            pc = m_target(fetch_pc, fetch_instr);
        end else if (m_is_ret(fetch_instr) && m_ras.size() > 0) begin
            t  = 1'b1;
            pc = m_ras[$];
        end
    endtask

    task automatic m_resolve(output logic r, output logic [31:0] rpc);
        logic [5:0]  op;
        logic [31:0] a;
        r = 1'b0;
        rpc = 32'd0;
        if (res_valid && !reset) begin
            op = res_instr[31:26];
            a  = res_pc + 32'd4;
            if (op == 6'd4 && res_eq)       a = m_target(res_pc, res_instr);
            else if (op == 6'd5 && !res_eq) a = m_target(res_pc, res_instr);
            else if (op == 6'd2 || op == 6'd3) a = m_target(res_pc, res_instr);
            else if (m_is_jr(res_instr))    a = res_vs;
            r   = (a != res_pred_pc);
            rpc = a;
        end
    endtask

    task automatic m_commit(input logic was_redirect);
        logic [5:0] op;
        int         idx;
        bit         tk;
        if (reset) begin
            foreach (m_bht[i]) m_bht[i] = 2;
            m_ras.delete();
        end else if (!stall) begin
            op = res_instr[31:26];
            if (res_valid && (op == 6'd4 || op == 6'd5)) begin
                idx = int'(res_pc[5:2]);
                tk  = (op == 6'd4) ? res_eq : !res_eq;
                if (tk && m_bht[idx] < 3) m_bht[idx]++;
                if (!tk && m_bht[idx] > 0) m_bht[idx]--;
            end
            if (!was_redirect) begin
                if (fetch_instr[31:26] == 6'd3) begin
                    m_ras.push_back(fetch_pc + 32'd4);
                    if (m_ras.size() > NRAS) void'(m_ras.pop_front());
                end else if (m_is_ret(fetch_instr) && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // one clock: compare all outputs against the model, then advance the model
    task automatic cycle();
        logic        et, er;
        logic [31:0] ep, erp;
        @(negedge clk);
        m_predict(et, ep);
        m_resolve(er, erp);
        s_pred_taken  = pred_taken;
        s_pred_pc     = pred_pc;
        s_redirect    = redirect;
        s_redirect_pc = redirect_pc;
        chk("pred_taken",  {31'd0, pred_taken}, {31'd0, et});
        chk("pred_pc",     pred_pc, ep);
        chk("redirect",    {31'd0, redirect}, {31'd0, er});
        chk("redirect_pc", redirect_pc, erp);
        m_commit(er);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] ins);
        fetch_pc    = pc;
        fetch_instr = ins;
    endtask

    task automatic resolve(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] ppc, input logic eq, input logic [31:0] vs);
        res_valid   = v;
        res_pc      = pc;
        res_instr   = ins;
        res_pred_pc = ppc;
        res_eq      = eq;
        res_vs      = vs;
    endtask

    function automatic logic [31:0] rand_instr();
        case ($urandom_range(0, 6))
            0: return enc_br(1'b0, 16'($urandom));
            1: return enc_br(1'b1, 16'($urandom));
            2: return enc_j(1'b0, 26'($urandom));
            3: return enc_j(1'b1, 26'($urandom));
            4: return enc_jr(5'd31);
            5: return enc_jr(5'($urandom_range(0, 30)));
            default: return {6'h08, 26'($urandom)};
        endcase
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) == 0) return r & 32'hFFFF_FFFC;
        return {22'd0, r[7:0], 2'b00};
    endfunction

    logic [31:0] ret_exp [4];

    initial begin
        foreach (m_bht[i]) m_bht[i] = 2;
        reset = 1'b1;
        stall = 1'b0;
        fetch(32'h100, NOP);
        resolve(1'b1, 32'h40, enc_br(1'b0, 16'd4), 32'h0, 1'b1, 32'h0);

        // reset state
        cycle();
        cycle();
        chk("lit_reset_redirect", {31'd0, s_redirect}, 32'd0);
        chk("lit_reset_pred_pc", s_pred_pc, 32'h104);
        reset = 1'b0;

        // beq at 0x100 imm=4, weakly taken at reset
        resolve(1'b0, 32'h0, NOP, 32'h0, 1'b0, 32'h0);
        fetch(32'h100, enc_br(1'b0, 16'd4));
        cycle();
        chk("lit_beq_taken", {31'd0, s_pred_taken}, 32'd1);
        chk("lit_beq_pc", s_pred_pc, 32'h114);

        // resolve not-taken twice
        fetch(32'h104, NOP);
        resolve(1'b1, 32'h100, enc_br(1'b0, 16'd4), 32'h114, 1'b0, 32'h0);
        repeat (2) begin
            cycle();
            chk("lit_nt_redirect", {31'd0, s_redirect}, 32'd1);
            chk("lit_nt_redirect_pc", s_redirect_pc, 32'h104);
        end
        resolve(1'b0, 32'h0, NOP, 32'h0, 1'b0, 32'h0);
        fetch(32'h100, enc_br(1'b0, 16'd4));
        cycle();
        chk("lit_nt_pred_pc", s_pred_pc, 32'h104);
        chk("lit_nt_pred_taken", {31'd0, s_pred_taken}, 32'd0);

        // four taken (saturate at 3), then one not-taken -> still taken
        fetch(32'h104, NOP);
        resolve(1'b1, 32'h100, enc_br(1'b0, 16'd4), 32'h114, 1'b1, 32'h0);
        repeat (4) cycle();
        resolve(1'b1, 32'h100, enc_br(1'b0, 16'd4), 32'h104, 1'b0, 32'h0);
        cycle();
        resolve(1'b0, 32'h0, NOP, 32'h0, 1'b0, 32'h0);
        fetch(32'h100, enc_br(1'b0, 16'd4));
        cycle();
        chk("lit_sat_taken", {31'd0, s_pred_taken}, 32'd1);

        // stall blocks BHT training
        stall = 1'b1;
        fetch(32'h104, NOP);
        resolve(1'b1, 32'h100, enc_br(1'b0, 16'd4), 32'h104, 1'b0, 32'h0);
        repeat (2) cycle();
        stall = 1'b0;
        resolve(1'b0, 32'h0, NOP, 32'h0, 1'b0, 32'h0);
        fetch(32'h100, enc_br(1'b0, 16'd4));
        cycle();
        chk("lit_stall_taken", {31'd0, s_pred_taken}, 32'd1);

        // jal then return
        fetch(32'h200, enc_j(1'b1, 26'h40));
        cycle();
        fetch(32'h400, enc_jr(5'd31));
        cycle();
        chk("lit_ret_pc", s_pred_pc, 32'h204);
        chk("lit_ret_taken", {31'd0, s_pred_taken}, 32'd1);
        fetch(32'h300, enc_jr(5'd31));
        cycle();
        chk("lit_empty_ret_pc", s_pred_pc, 32'h304);
        chk("lit_empty_ret_taken", {31'd0, s_pred_taken}, 32'd0);
        fetch(32'h304, NOP);
        resolve(1'b1, 32'h300, enc_jr(5'd31), 32'h304, 1'b0, 32'h500);
        cycle();
        chk("lit_jr_redirect", {31'd0, s_redirect}, 32'd1);
        chk("lit_jr_redirect_pc", s_redirect_pc, 32'h500);
        resolve(1'b0, 32'h0, NOP, 32'h0, 1'b0, 32'h0);

        // five pushes into a depth-4 stack, five pops
        for (int i = 0; i < 5; i++) begin
            fetch(32'h1000 + 32'(16 * i), enc_j(1'b1, 26'h80));
            cycle();
        end
        ret_exp[0] = 32'h1044;
        ret_exp[1] = 32'h1034;
        ret_exp[2] = 32'h1024;
        ret_exp[3] = 32'h1014;
        for (int i = 0; i < 4; i++) begin
            fetch(32'h2000, enc_jr(5'd31));
            cycle();
            chk("lit_ras_pop", s_pred_pc, ret_exp[i]);
        end
        cycle();
        chk("lit_ras_empty_pc", s_pred_pc, 32'h2004);
        chk("lit_ras_empty_taken", {31'd0, s_pred_taken}, 32'd0);

        // redirect cancels a wrong-path jal push
        fetch(32'h600, enc_j(1'b1, 26'h10));
        resolve(1'b1, 32'h300, enc_jr(5'd31), 32'h304, 1'b0, 32'h500);
        cycle();
        resolve(1'b0, 32'h0, NOP, 32'h0, 1'b0, 32'h0);
        fetch(32'h700, enc_jr(5'd31));
        cycle();
        chk("lit_redir_ras_pc", s_pred_pc, 32'h704);

        // reset mid-sequence
        fetch(32'h104, NOP);
        resolve(1'b1, 32'h100, enc_br(1'b0, 16'd4), 32'h114, 1'b0, 32'h0);
        repeat (2) cycle();
        fetch(32'h800, enc_j(1'b1, 26'h10));
        resolve(1'b0, 32'h0, NOP, 32'h0, 1'b0, 32'h0);
        cycle();
        reset = 1'b1;
        fetch(32'h804, NOP);
        resolve(1'b1, 32'h100, enc_br(1'b0, 16'd4), 32'h114, 1'b0, 32'h0);
        cycle();
        chk("lit_mid_reset_redirect", {31'd0, s_redirect}, 32'd0);
        chk("lit_mid_reset_redirect_pc", s_redirect_pc, 32'd0);
        reset = 1'b0;
        resolve(1'b0, 32'h0, NOP, 32'h0, 1'b0, 32'h0);
        fetch(32'h900, enc_jr(5'd31));
        cycle();
        chk("lit_post_reset_ras", s_pred_pc, 32'h904);
        fetch(32'h100, enc_br(1'b0, 16'd4));
        cycle();
        chk("lit_post_reset_bht", s_pred_pc, 32'h114);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] rp, ri;
            reset = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 4) == 0);
            fetch(rand_pc(), rand_instr());
            rp = rand_pc();
            ri = rand_instr();
            case ($urandom_range(0, 3))
                0: resolve($urandom_range(0, 9) < 7, rp, ri, rp + 32'd4, 1'($urandom), rand_pc());
                1: resolve($urandom_range(0, 9) < 7, rp, ri, m_target(rp, ri), 1'($urandom), rand_pc());
                default: resolve($urandom_range(0, 9) < 7, rp, ri, rand_pc(), 1'($urandom), rand_pc());
            endcase
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
